fb_scanout: RTL and testbench

FB_SCANOUT -- requirements
Module: fb_scanout

---
 rtl/fb_scanout.sv | 157 +++++++++++++++
 tb/tb_fb_scanout.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: VGA scan-out engine for a 2x2-upscaled framebuffer.
//
// Runs free-running horizontal/vertical timing counters on the pixel-clock
// enable, issues one framebuffer read per active pixel and drives the VGA pins
// through a two-stage pipeline so colour, syncs and de share one latency.
//
// Ports
//   clk          in   single clock for all logic
//   rst_n        in   asynchronous active-low reset
//   pix_ce       in   pixel-clock enable; everything advances only when high
//   fb_re        out  framebuffer read strobe, one clk wide
//   fb_addr      out  framebuffer read address (row-major, W pixels per row)
//   fb_rdata     in   read data; R=[11:8] G=[7:4] B=[3:0], upper bits ignored
//   hsync/vsync  out  active-low VGA syncs
//   vga_r/g/b    out  4-bit colour, zero outside active video
//   de           out  high while vga_r/g/b carry active video
//   vblank_start out  one-clk pulse when scanning enters vertical blanking
module fb_scanout #(
  parameter int W        = 320,
  parameter int H        = 240,
  parameter int PIX_BITS = 16,
  parameter int ADDR_W   = 17,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pix_ce,
  output logic                fb_re,
  output logic [ADDR_W-1:0]   fb_addr,
  input  logic [PIX_BITS-1:0] fb_rdata,
  output logic                hsync,
  output logic                vsync,
  output logic [3:0]          vga_r,
  output logic [3:0]          vga_g,
  output logic [3:0]          vga_b,
  output logic                de,
  output logic                vblank_start
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HCW   = $clog2(H_TOT);
  localparam int VCW   = $clog2(V_TOT);

  localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOT - 1);
  localparam logic [HCW-1:0] H_ACT_C  = HCW'(H_ACT);
  localparam logic [HCW-1:0] H_SYNC_S = HCW'(H_ACT + H_FP);
  localparam logic [HCW-1:0] H_SYNC_E = HCW'(H_ACT + H_FP + H_SYNC);
  localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOT - 1);
  localparam logic [VCW-1:0] V_ACT_C  = VCW'(V_ACT);
  localparam logic [VCW-1:0] V_ACT_L  = VCW'(V_ACT - 1);
  localparam logic [VCW-1:0] V_SYNC_S = VCW'(V_ACT + V_FP);
  localparam logic [VCW-1:0] V_SYNC_E = VCW'(V_ACT + V_FP + V_SYNC);

  // The 2x2 upscale only lines up when the framebuffer is exactly half the
  // active raster in each direction.
  if (W * 2 != H_ACT || H * 2 != V_ACT) begin : g_geometry_check
    $error("fb_scanout: W and H must be half of H_ACT and V_ACT");
  end

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           act_raw;
  logic           hs_raw;
  logic           vs_raw;
  logic           act_p0;
  logic           hs_p0;
  logic           vs_p0;

  // Padding bits of the stored pixel carry no colour.
  logic unused_pad;
  assign unused_pad = ^fb_rdata[PIX_BITS-1:12];

  // Each framebuffer pixel covers a 2x2 block of screen pixels, so both
  // coordinates are halved before the row-major address is formed.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [HCW-1:0] h,
                                                 input logic [VCW-1:0] v);
    logic [31:0] row;
    logic [31:0] col;
    logic [31:0] lin;
    row = 32'(v >> 1);
    col = 32'(h >> 1);
    lin = row * 32'(W) + col;
    return lin[ADDR_W-1:0];
  endfunction

  assign act_raw = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs_raw  = !((h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E));
  assign vs_raw  = !((v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E));

  // Raster position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Stage 0: issue the read and delay syncs/active to meet the returning data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_re        <= 1'b0;
      fb_addr      <= '0;
      act_p0       <= 1'b0;
      hs_p0        <= 1'b1;
      vs_p0        <= 1'b1;
      vblank_start <= 1'b0;
    end else begin
      // Strobes are recomputed every clk so they drop after one clk even when
      // pix_ce is sparse.
      fb_re        <= pix_ce && act_raw;
      vblank_start <= pix_ce && (h_cnt == H_LAST) && (v_cnt == V_ACT_L);
      if (pix_ce) begin
        act_p0 <= act_raw;
        hs_p0  <= hs_raw;
        vs_p0  <= vs_raw;
        if (act_raw) begin
          fb_addr <= pix_addr(h_cnt, v_cnt);
        end
      end
    end
  end

  // Stage 1: drive the pins from the delayed controls and the read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de    <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      vga_r <= 4'h0;
      vga_g <= 4'h0;
      vga_b <= 4'h0;
    end else if (pix_ce) begin
      de    <= act_p0;
      hsync <= hs_p0;
      vsync <= vs_p0;
      vga_r <= act_p0 ? fb_rdata[11:8] : 4'h0;
      vga_g <= act_p0 ? fb_rdata[7:4]  : 4'h0;
      vga_b <= act_p0 ? fb_rdata[3:0]  : 4'h0;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout, using a reduced raster so whole frames fit
// in a short run: 8x4 framebuffer, 16x8 active, 24x13 total (312 ticks/frame),
// hsync low at h in [18,21), vsync low on line 10.
module tb_fb_scanout;

  localparam int W        = 8;
  localparam int H        = 4;
  localparam int PIX_BITS = 16;
  localparam int ADDR_W   = 17;
  localparam int H_ACT    = 16;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACT    = 8;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 1;
  localparam int V_BP     = 2;
  localparam int H_TOT    = 24;
  localparam int V_TOT    = 13;
  localparam int FRAME    = 312;

  logic                clk;
  logic                rst_n;
  logic                pix_ce;
  logic                fb_re;
  logic [ADDR_W-1:0]   fb_addr;
  logic [PIX_BITS-1:0] fb_rdata;
  logic                hsync;
  logic                vsync;
  logic [3:0]          vga_r;
  logic [3:0]          vga_g;
  logic [3:0]          vga_b;
  logic                de;
  logic                vblank_start;

  fb_scanout #(
    .W(W), .H(H), .PIX_BITS(PIX_BITS), .ADDR_W(ADDR_W),
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .fb_re(fb_re), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
    .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .de(de), .vblank_start(vblank_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer model: each word is tagged with its own address, padding 0xA.
  logic                const_mode;
  logic [PIX_BITS-1:0] rd_hold;

  function automatic logic [15:0] tag(input logic [ADDR_W-1:0] a);
    return {4'hA, a[11:0]};
  endfunction

  always @(posedge clk) if (fb_re) rd_hold <= tag(fb_addr);
  assign fb_rdata = const_mode ? 16'hFF22 : (fb_re ? tag(fb_addr) : rd_hold);

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic              fb_re;
    logic [ADDR_W-1:0] fb_addr;
    logic              de;
    logic              hs;
    logic              vs;
    logic              vb;
    logic [11:0]       rgb;
    int                src_h;
    int                src_v;
  } exp_t;

  exp_t q[$];

  // Reference raster model owned by the stimulus side.
  int                mh, mv, s_h, s_v;
  logic              s_act, s_hs, s_vs;
  logic [15:0]       s_data;
  logic [ADDR_W-1:0] last_addr;

  task automatic model_reset();
    mh = 0; mv = 0; s_h = -1; s_v = -1;
    s_act = 1'b0; s_hs = 1'b1; s_vs = 1'b1; s_data = 16'h0;
    last_addr = '0;
  endtask

  // Called at the negedge before a pix_ce edge: pushes what the pins must show
  // after that edge, then advances the model.
  task automatic issue_tick();
    exp_t e;
    logic act;
    int   a;
    act = (mh < H_ACT) && (mv < V_ACT);
    a   = (mv / 2) * W + (mh / 2);
    if (act) last_addr = ADDR_W'(a);
    e.fb_re   = act;
    e.fb_addr = last_addr;
    e.de      = s_act;
    e.hs      = s_hs;
    e.vs      = s_vs;
    e.rgb     = s_act ? s_data[11:0] : 12'h0;
    e.vb      = (mh == H_TOT - 1) && (mv == V_ACT - 1);
    e.src_h   = s_h;
    e.src_v   = s_v;
    q.push_back(e);
    s_act  = act;
    s_hs   = !((mh >= H_ACT + H_FP) && (mh < H_ACT + H_FP + H_SYNC));
    s_vs   = !((mv >= V_ACT + V_FP) && (mv < V_ACT + V_FP + V_SYNC));
    s_data = const_mode ? 16'hFF22 : tag(ADDR_W'(a));
    s_h    = mh;
    s_v    = mv;
    mh++;
    if (mh == H_TOT) begin
      mh = 0;
      mv++;
      if (mv == V_TOT) mv = 0;
    end
  endtask

  // Monitor statistics, cleared by the stimulus side at phase starts.
  int edge_k, hs_low, vs_low, vb_cnt, first_hs_k;
  int vs_fall[$];

  task automatic clear_stats();
    edge_k = 0; hs_low = 0; vs_low = 0; vb_cnt = 0; first_hs_k = -1;
    vs_fall.delete();
  endtask

  // Monitor
  initial begin : monitor
    exp_t              e;
    logic              ce_s, rst_s;
    logic              l_hs, l_vs, l_de;
    logic [ADDR_W-1:0] l_addr;
    logic [11:0]       l_rgb;
    forever begin
      @(posedge clk);
      ce_s  = pix_ce;
      rst_s = rst_n;
      #1;
      if (rst_s && rst_n) begin
        if (ce_s) begin
          if (q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL queue_underflow: got empty scoreboard expected entry");
          end else begin
            e = q.pop_front();
            check("fb_re",   32'(fb_re),        32'(e.fb_re));
            check("fb_addr", 32'(fb_addr),      32'(e.fb_addr));
            check("de",      32'(de),           32'(e.de));
            check("hsync",   32'(hsync),        32'(e.hs));
            check("vsync",   32'(vsync),        32'(e.vs));
            check("vblank",  32'(vblank_start), 32'(e.vb));
            check("rgb",     32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
            if (e.src_h == 3 && e.src_v == 5 && !const_mode)
              check("pix_3_5_addr17", 32'({vga_r, vga_g, vga_b}), 32'h011);
            if (!hsync) begin
              hs_low++;
              if (first_hs_k < 0) first_hs_k = edge_k;
            end
            if (!vsync) vs_low++;
            if (l_vs && !vsync) vs_fall.push_back(edge_k);
            if (vblank_start) vb_cnt++;
            edge_k++;
          end
        end else begin
          check("idle_fb_re",  32'(fb_re),        32'd0);
          check("idle_vblank", 32'(vblank_start), 32'd0);
          check("hold_addr",   32'(fb_addr),      32'(l_addr));
          check("hold_hsync",  32'(hsync),        32'(l_hs));
          check("hold_vsync",  32'(vsync),        32'(l_vs));
          check("hold_de",     32'(de),           32'(l_de));
          check("hold_rgb",    32'({vga_r, vga_g, vga_b}), 32'(l_rgb));
        end
      end
      l_hs   = hsync;
      l_vs   = vsync;
      l_de   = de;
      l_addr = fb_addr;
      l_rgb  = {vga_r, vga_g, vga_b};
    end
  end

  task automatic check_reset_vals();
    check("rst_fb_re",  32'(fb_re),        32'd0);
    check("rst_addr",   32'(fb_addr),      32'd0);
    check("rst_hsync",  32'(hsync),        32'd1);
    check("rst_vsync",  32'(vsync),        32'd1);
    check("rst_de",     32'(de),           32'd0);
    check("rst_rgb",    32'({vga_r, vga_g, vga_b}), 32'd0);
    check("rst_vblank", 32'(vblank_start), 32'd0);
  endtask

  task automatic run(input int ticks, input int div);
    for (int t = 0; t < ticks; t++) begin
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        if (c == 0) begin
          issue_tick();
          pix_ce = 1'b1;
        end else begin
          pix_ce = 1'b0;
        end
      end
    end
    @(negedge clk);
    pix_ce = 1'b0;
  endtask

  task automatic do_reset(input logic cmode);
    @(negedge clk);
    rst_n  = 1'b0;
    pix_ce = 1'b0;
    q.delete();
    model_reset();
    const_mode = cmode;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    clear_stats();
  endtask

  initial begin : stimulus
    rst_n      = 1'b0;
    pix_ce     = 1'b0;
    const_mode = 1'b0;
    model_reset();
    clear_stats();
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    clear_stats();

    // Two frames with pix_ce tied high: timing and sync statistics.
    run(2 * FRAME, 1);
    check("hs_low_ticks",   32'(hs_low),     32'd78);
    check("vs_low_ticks",   32'(vs_low),     32'd48);
    check("vblank_pulses",  32'(vb_cnt),     32'd2);
    check("first_hs_low_k", 32'(first_hs_k), 32'd19);
    check("vs_fall_count",  32'(vs_fall.size()), 32'd2);
    if (vs_fall.size() == 2) begin
      check("vs_first_fall", 32'(vs_fall[0]), 32'd241);
      check("frame_ticks",   32'(vs_fall[1] - vs_fall[0]), 32'(FRAME));
    end

    // Mid-frame reset at (h=10, v=5), pix_ce kept high during reset.
    run(5 * H_TOT + 10, 1);
    @(negedge clk);
    pix_ce = 1'b1;
    rst_n  = 1'b0;
    q.delete();
    model_reset();
    #1;
    check_reset_vals();
    repeat (3) begin
      @(negedge clk);
      check_reset_vals();
    end
    rst_n = 1'b1;
    clear_stats();
    issue_tick();
    @(posedge clk);
    #1;
    check("restart_fb_re", 32'(fb_re),   32'd1);
    check("restart_addr",  32'(fb_addr), 32'd0);
    run(40, 1);

    // pix_ce every 4th clk, tagged data.
    do_reset(1'b0);
    run(200, 4);
    check("div4_vblank_pulses", 32'(vb_cnt), 32'd1);

    // Constant pixel word with padding set.
    do_reset(1'b1);
    run(200, 1);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
